// File: rtl/cache_ctrl_nway_if.sv
// cache_ctrl_nway_if: lookup request / hit-miss result bus between requester and cache controller
interface cache_ctrl_nway_if #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 16,
  parameter int WAYS    = 4
);
  localparam int WAY_W = $clog2(WAYS);
  logic [INDEX_W-1:0] index_i;
  logic [TAG_W-1:0]   tag_i;
  logic               it_valid_i;
  logic               it_ready_o;
  logic               flush_i;
  logic               hm_valid_o;
  logic               hm_ready_i;
  logic               hit_miss_o;
  logic [WAY_W-1:0]   col_o;
  modport master (
    output index_i, tag_i, it_valid_i, flush_i, hm_ready_i,
    input  it_ready_o, hm_valid_o, hit_miss_o, col_o
  );
  modport slave (
    input  index_i, tag_i, it_valid_i, flush_i, hm_ready_i,
    output it_ready_o, hm_valid_o, hit_miss_o, col_o
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative tag lookup with matrix LRU replacement and walk-based flush
module cache_ctrl_nway #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 16,
  parameter int WAYS    = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  cache_ctrl_nway_if.slave  bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);
  typedef enum logic [2:0] {INIT, IDLE, CHECK, FINISH, FLUSH} state_t;
  state_t             state;
  logic [INDEX_W-1:0] walk_q;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WAYS-1:0]    hit_q;
  logic [WAY_W-1:0]   vic_q;
  logic               ready_q;
  logic               hm_valid_q;
  logic               hit_miss_q;
  logic [WAY_W-1:0]   col_q;
  logic [TAG_W-1:0]   tag_mem [SETS][WAYS];
  logic [WAYS-1:0]    val_mem [SETS];
  logic [WAYS-1:0]    lru_mem [SETS][WAYS];
  logic [TAG_W-1:0]   tag_rd [WAYS];
  logic [WAYS-1:0]    val_rd;
  logic [WAYS-1:0]    lru_rd [WAYS];
  logic [WAYS-1:0]    lru_wr [WAYS];
  logic [WAYS-1:0]    hit_vec;
  logic [WAY_W-1:0]   vic;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   acc_way;
  logic               accept;
  logic               walk;
  logic               hs;
  logic               hit_any;
  assign accept  = state == IDLE && bus.it_valid_i && !bus.flush_i;
  assign walk    = rst_ni && (state == INIT || state == FLUSH);
  assign hs      = rst_ni && state == FINISH && hm_valid_q && bus.hm_ready_i;
  assign hit_any = |hit_q;
  assign bus.it_ready_o = ready_q;
  assign bus.hm_valid_o = hm_valid_q;
  assign bus.hit_miss_o = hit_miss_q;
  assign bus.col_o      = col_q;
  // tag compare, victim choice (invalid way first, else LRU row of zeros), lowest-index hit encode
  always_comb begin
    hit_vec = '0;
    vic     = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = val_rd[w] && tag_rd[w] == tag_q;
      if (lru_rd[w] == '0) vic = WAY_W'(w);
      if (hit_q[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!val_rd[w]) vic = WAY_W'(w);
  end
  // LRU matrix after an access: accessed row all ones but its diagonal, its column cleared everywhere
  always_comb begin
    acc_way = hit_any ? hit_way : vic_q;
    lru_wr  = lru_rd;
    for (int r = 0; r < WAYS; r++)
      lru_wr[r] = WAY_W'(r) == acc_way ? ~(WAYS'(1) << acc_way) : lru_rd[r] & ~(WAYS'(1) << acc_way);
  end
  // set arrays: synchronous read on acceptance, writes only during the walk or on the result handshake
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_rd <= tag_mem[bus.index_i];
      val_rd <= val_mem[bus.index_i];
      lru_rd <= lru_mem[bus.index_i];
    end
    if (walk) begin
      val_mem[walk_q] <= '0;
      lru_mem[walk_q] <= '{default: '0};
    end else if (hs) begin
      lru_mem[idx_q] <= lru_wr;
      if (!hit_any) begin
        tag_mem[idx_q][vic_q] <= tag_q;
        val_mem[idx_q]        <= val_rd | (WAYS'(1) << vic_q);
      end
    end
  end
  // controller FSM with registered handshake and result outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= INIT;
      walk_q     <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      hit_q      <= '0;
      vic_q      <= '0;
      ready_q    <= 1'b0;
      hm_valid_q <= 1'b0;
      hit_miss_q <= 1'b0;
      col_q      <= '0;
    end else begin
      case (state)
        INIT, FLUSH: begin
          walk_q <= walk_q + INDEX_W'(1);
          if (&walk_q) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (bus.flush_i) begin
            state   <= FLUSH;
            walk_q  <= '0;
            ready_q <= 1'b0;
          end else if (bus.it_valid_i) begin
            state   <= CHECK;
            tag_q   <= bus.tag_i;
            idx_q   <= bus.index_i;
            ready_q <= 1'b0;
          end
        end
        CHECK: begin
          hit_q <= hit_vec;
          vic_q <= vic;
          state <= FINISH;
        end
        FINISH: begin
          if (!hm_valid_q) begin
            hm_valid_q <= 1'b1;
            hit_miss_q <= hit_any;
            col_q      <= hit_any ? hit_way : vic_q;
          end else if (bus.hm_ready_i) begin
            hm_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
